// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, issues one imem request at a time, fills the IF/ID register.
// Latency: grant in cycle N, response in N+1, IF_ID_vld from N+2 (one instruction per two cycles).
// Backpressure: ID_stall parks an early response in a one-entry hold buffer; redirects flush and drain stale responses.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ID_stall,
    input  logic        EX_redirect,
    input  logic [31:0] EX_redirect_pc,
    input  logic        Imem_req_rdy,
    input  logic        Imem_rsp_vld,
    input  logic [31:0] Imem_rsp_data,
    output logic        proc2Imem_req,
    output logic [31:0] proc2Imem_addr,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_inst,
    output logic        IF_ID_vld
);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_DRAIN} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_vld_q, id_vld_d;
    logic        load;
    logic [31:0] redirect_pc;
    logic        unused_redirect_lsbs;

    assign redirect_pc          = {EX_redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^EX_redirect_pc[1:0];

    // A bubble in IF/ID can always be overwritten, even while decode stalls.
    assign load = !ID_stall || !id_vld_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hold_pc_d   = hold_pc_q;
        hold_inst_d = hold_inst_q;
        id_pc_d     = id_pc_q;
        id_inst_d   = id_inst_q;
        id_vld_d    = ID_stall ? id_vld_q : 1'b0;

        case (state_q)
            S_FETCH: begin
                if (Imem_req_rdy) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (Imem_rsp_vld) begin
                    pc_d = pc_q + 32'd4;
                    if (load) begin
                        id_pc_d   = pc_q;
                        id_inst_d = Imem_rsp_data;
                        id_vld_d  = 1'b1;
                        state_d   = S_FETCH;
                    end else begin
                        hold_pc_d   = pc_q;
                        hold_inst_d = Imem_rsp_data;
                        state_d     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!ID_stall) begin
                    id_pc_d   = hold_pc_q;
                    id_inst_d = hold_inst_q;
                    id_vld_d  = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (Imem_rsp_vld) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Redirect overrides everything above; a same-cycle response belongs to the old path.
        if (EX_redirect) begin
            pc_d      = redirect_pc;
            id_pc_d   = id_pc_q;
            id_inst_d = id_inst_q;
            id_vld_d  = 1'b0;
            case (state_q)
                S_FETCH: state_d = Imem_req_rdy ? S_DRAIN : S_FETCH;
                S_WAIT:  state_d = Imem_rsp_vld ? S_FETCH : S_DRAIN;
                S_HOLD:  state_d = S_FETCH;
                S_DRAIN: state_d = Imem_rsp_vld ? S_FETCH : S_DRAIN;
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            hold_pc_q   <= RESET_PC;
            hold_inst_q <= NOP_INST;
            id_pc_q     <= RESET_PC;
            id_inst_q   <= NOP_INST;
            id_vld_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_pc_q   <= hold_pc_d;
            hold_inst_q <= hold_inst_d;
            id_pc_q     <= id_pc_d;
            id_inst_q   <= id_inst_d;
            id_vld_q    <= id_vld_d;
        end
    end

    assign proc2Imem_req  = (state_q == S_FETCH) && !rst;
    assign proc2Imem_addr = pc_q;
    assign IF_ID_pc       = id_pc_q;
    assign IF_ID_inst     = id_inst_q;
    assign IF_ID_vld      = id_vld_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch cadence, stall/hold, redirect drain, PC wrap, mid-flight reset.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ID_stall;
    logic        EX_redirect;
    logic [31:0] EX_redirect_pc;
    logic        Imem_req_rdy;
    logic        Imem_rsp_vld;
    logic [31:0] Imem_rsp_data;
    logic        proc2Imem_req;
    logic [31:0] proc2Imem_addr;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_inst;
    logic        IF_ID_vld;

    int n_checks = 0;
    int n_fail   = 0;

    if_stage dut (
        .clk            (clk),
        .rst            (rst),
        .ID_stall       (ID_stall),
        .EX_redirect    (EX_redirect),
        .EX_redirect_pc (EX_redirect_pc),
        .Imem_req_rdy   (Imem_req_rdy),
        .Imem_rsp_vld   (Imem_rsp_vld),
        .Imem_rsp_data  (Imem_rsp_data),
        .proc2Imem_req  (proc2Imem_req),
        .proc2Imem_addr (proc2Imem_addr),
        .IF_ID_pc       (IF_ID_pc),
        .IF_ID_inst     (IF_ID_inst),
        .IF_ID_vld      (IF_ID_vld)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Grant one request at exp_addr, then return data the following cycle.
    task automatic do_fetch(input string tag, input logic [31:0] exp_addr,
                            input logic [31:0] data, input logic exp_wait_vld);
        chk({tag, ".req"}, {31'd0, proc2Imem_req}, 32'd1);
        chk({tag, ".addr"}, proc2Imem_addr, exp_addr);
        Imem_req_rdy = 1'b1;
        step();
        Imem_req_rdy = 1'b0;
        chk({tag, ".wait_req"}, {31'd0, proc2Imem_req}, 32'd0);
        chk({tag, ".wait_vld"}, {31'd0, IF_ID_vld}, {31'd0, exp_wait_vld});
        Imem_rsp_vld  = 1'b1;
        Imem_rsp_data = data;
        step();
        Imem_rsp_vld  = 1'b0;
        Imem_rsp_data = 32'h0;
    endtask

    initial begin
        rst            = 1'b1;
        ID_stall       = 1'b0;
        EX_redirect    = 1'b0;
        EX_redirect_pc = 32'h0;
        Imem_req_rdy   = 1'b0;
        Imem_rsp_vld   = 1'b0;
        Imem_rsp_data  = 32'h0;
        step();
        step();
        chk("rst.req_low", {31'd0, proc2Imem_req}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst.req", {31'd0, proc2Imem_req}, 32'd1);
        chk("rst.addr", proc2Imem_addr, 32'h0000_0000);
        chk("rst.vld", {31'd0, IF_ID_vld}, 32'd0);
        chk("rst.inst", IF_ID_inst, 32'h0000_0013);
        chk("rst.pc", IF_ID_pc, 32'h0000_0000);

        // 1: back-to-back fetches, valid pulses every other cycle
        do_fetch("t1.f0", 32'h0, 32'hA000_0000, 1'b0);
        chk("t1.vld0", {31'd0, IF_ID_vld}, 32'd1);
        chk("t1.pc0", IF_ID_pc, 32'h0);
        chk("t1.inst0", IF_ID_inst, 32'hA000_0000);
        do_fetch("t1.f1", 32'h4, 32'hA000_0004, 1'b0);
        chk("t1.pc1", IF_ID_pc, 32'h4);
        chk("t1.inst1", IF_ID_inst, 32'hA000_0004);
        do_fetch("t1.f2", 32'h8, 32'hA000_0008, 1'b0);
        chk("t1.vld2", {31'd0, IF_ID_vld}, 32'd1);
        chk("t1.pc2", IF_ID_pc, 32'h8);
        chk("t1.inst2", IF_ID_inst, 32'hA000_0008);

        // 2: stall during WAIT parks the response in the hold buffer
        do_fetch("t2.fc", 32'hC, 32'hA000_000C, 1'b0);
        chk("t2.pcC", IF_ID_pc, 32'hC);
        ID_stall = 1'b1;
        do_fetch("t2.f10", 32'h10, 32'hA000_0010, 1'b1);
        chk("t2.hold_pc", IF_ID_pc, 32'hC);
        chk("t2.hold_inst", IF_ID_inst, 32'hA000_000C);
        chk("t2.hold_vld", {31'd0, IF_ID_vld}, 32'd1);
        chk("t2.hold_req", {31'd0, proc2Imem_req}, 32'd0);
        step();
        chk("t2.hold2_pc", IF_ID_pc, 32'hC);
        ID_stall = 1'b0;
        step();
        chk("t2.rel_pc", IF_ID_pc, 32'h10);
        chk("t2.rel_inst", IF_ID_inst, 32'hA000_0010);
        chk("t2.rel_vld", {31'd0, IF_ID_vld}, 32'd1);
        chk("t2.next_req", {31'd0, proc2Imem_req}, 32'd1);
        chk("t2.next_addr", proc2Imem_addr, 32'h14);

        // 3: redirect while WAIT at 0x40 drains the stale response
        EX_redirect    = 1'b1;
        EX_redirect_pc = 32'h40;
        step();
        EX_redirect = 1'b0;
        chk("t3.addr40", proc2Imem_addr, 32'h40);
        chk("t3.flush_vld", {31'd0, IF_ID_vld}, 32'd0);
        Imem_req_rdy = 1'b1;
        step();
        Imem_req_rdy   = 1'b0;
        EX_redirect    = 1'b1;
        EX_redirect_pc = 32'h203;
        step();
        EX_redirect = 1'b0;
        chk("t3.drain_req", {31'd0, proc2Imem_req}, 32'd0);
        chk("t3.drain_addr", proc2Imem_addr, 32'h200);
        Imem_rsp_vld  = 1'b1;
        Imem_rsp_data = 32'hDEAD_0040;
        step();
        Imem_rsp_vld = 1'b0;
        chk("t3.post_vld", {31'd0, IF_ID_vld}, 32'd0);
        do_fetch("t3.f200", 32'h200, 32'hA000_0200, 1'b0);
        chk("t3.vld", {31'd0, IF_ID_vld}, 32'd1);
        chk("t3.pc", IF_ID_pc, 32'h200);
        chk("t3.inst", IF_ID_inst, 32'hA000_0200);

        // 4: redirect + response same WAIT cycle under stall
        ID_stall = 1'b1;
        chk("t4.addr", proc2Imem_addr, 32'h204);
        Imem_req_rdy = 1'b1;
        step();
        Imem_req_rdy   = 1'b0;
        chk("t4.wait_vld", {31'd0, IF_ID_vld}, 32'd1);
        EX_redirect    = 1'b1;
        EX_redirect_pc = 32'h300;
        Imem_rsp_vld   = 1'b1;
        Imem_rsp_data  = 32'hDEAD_0204;
        step();
        EX_redirect  = 1'b0;
        Imem_rsp_vld = 1'b0;
        chk("t4.vld", {31'd0, IF_ID_vld}, 32'd0);
        chk("t4.req", {31'd0, proc2Imem_req}, 32'd1);
        chk("t4.target", proc2Imem_addr, 32'h300);
        chk("t4.pc_hold", IF_ID_pc, 32'h200);
        ID_stall = 1'b0;

        // 5: PC wraps modulo 2^32
        EX_redirect    = 1'b1;
        EX_redirect_pc = 32'hFFFF_FFFE;
        step();
        EX_redirect = 1'b0;
        do_fetch("t5.ftop", 32'hFFFF_FFFC, 32'hA000_FFFC, 1'b0);
        chk("t5.pc", IF_ID_pc, 32'hFFFF_FFFC);
        chk("t5.inst", IF_ID_inst, 32'hA000_FFFC);
        chk("t5.wrap", proc2Imem_addr, 32'h0000_0000);

        // 6: reset during WAIT abandons the request
        EX_redirect    = 1'b1;
        EX_redirect_pc = 32'h80;
        step();
        EX_redirect  = 1'b0;
        Imem_req_rdy = 1'b1;
        step();
        Imem_req_rdy = 1'b0;
        chk("t6.wait_addr", proc2Imem_addr, 32'h80);
        rst = 1'b1;
        #1;
        chk("t6.rst_req", {31'd0, proc2Imem_req}, 32'd0);
        step();
        rst           = 1'b0;
        Imem_rsp_vld  = 1'b1;
        Imem_rsp_data = 32'hDEAD_0080;
        step();
        Imem_rsp_vld = 1'b0;
        chk("t6.req", {31'd0, proc2Imem_req}, 32'd1);
        chk("t6.addr", proc2Imem_addr, 32'h0000_0000);
        chk("t6.vld", {31'd0, IF_ID_vld}, 32'd0);
        chk("t6.inst", IF_ID_inst, 32'h0000_0013);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
